// File: rtl/sequence_serializer.sv
// sequence_serializer
//   Serializes the low in_len bits of a parallel word, MSB-first, one bit per
//   BIT_PERIOD-cycle slot. valid strobes once at the start of each slot and
//   qualifies seq. done pulses with the last bit's valid, or one cycle after
//   accepting a zero-length word.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high
//   in_data   word to send (low in_len bits, bit in_len-1 first)
//   in_len    number of bits to send, clamped to DATA_W
//   in_valid  producer offer
//   in_ready  high only in IDLE (registered)
//   abort     synchronous cancel of the word in flight
//   seq       serial bit, meaningful only while valid=1 (registered)
//   valid     one-cycle strobe per bit slot (registered)
//   busy      high outside IDLE (registered)
//   done      one-cycle end-of-word pulse (registered)
module sequence_serializer #(
  parameter  int DATA_W     = 16,
  parameter  int BIT_PERIOD = 1,
  localparam int LEN_W      = $clog2(DATA_W+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              seq,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [7:0]       PLAST = 8'(BIT_PERIOD - 1);
  localparam logic [LEN_W-1:0] LMAX  = LEN_W'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shreg;   // remaining bits, next one at the MSB
  logic [LEN_W-1:0]  rem;     // bits still to send after the one on seq
  logic [7:0]        pcnt;    // cycle within the current slot

  logic [LEN_W-1:0]  len_c;
  logic [LEN_W-1:0]  len_m1;
  logic [DATA_W-1:0] aligned;

  // Clamp the length and left-justify the word so the first bit to send
  // sits at the MSB; the shifter then only ever moves one way.
  always_comb begin
    len_c   = (in_len > LMAX) ? LMAX : in_len;
    len_m1  = len_c - LEN_W'(1);
    aligned = in_data << (LMAX - len_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      rem      <= '0;
      pcnt     <= '0;
      seq      <= 1'b0;
      valid    <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      // Strobes are single-cycle; seq is forced low whenever valid is low.
      valid <= 1'b0;
      seq   <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          pcnt <= '0;
          // in_ready is high throughout IDLE; abort wins over an offer.
          if (in_valid && !abort) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (len_c == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= SEND;
              valid <= 1'b1;
              seq   <= aligned[DATA_W-1];
              shreg <= aligned << 1;
              rem   <= len_m1;
              done  <= (len_m1 == '0);
            end
          end
        end
        SEND: begin
          if (abort) begin
            // The bit already on the outputs this cycle stands; the rest
            // of the word is dropped.
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            shreg    <= '0;
            rem      <= '0;
            pcnt     <= '0;
          end else if (pcnt == PLAST) begin
            pcnt <= '0;
            if (rem == '0) begin
              // Last slot fully elapsed.
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
              shreg    <= '0;
            end else begin
              valid <= 1'b1;
              seq   <= shreg[DATA_W-1];
              shreg <= shreg << 1;
              rem   <= rem - LEN_W'(1);
              done  <= (rem == LEN_W'(1));
            end
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end
        FINISH: begin
          // done was raised on entry; abort here has the same outcome.
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          shreg    <= '0;
          rem      <= '0;
          pcnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_serializer.sv
module tb_sequence_serializer;

  logic        clk;
  logic        reset;

  logic [15:0] a_data, b_data;
  logic [4:0]  a_len, b_len;
  logic        a_valid, b_valid, a_abort, b_abort;
  logic        a_rdy, b_rdy, a_seq, b_seq, a_vld, b_vld;
  logic        a_busy, b_busy, a_done, b_done;

  int n_chk;
  int n_fail;
  int cyc;

  typedef struct {
    int         cyc;
    logic [2:0] vsd;   // {valid, seq, done}
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  sequence_serializer #(.DATA_W(16), .BIT_PERIOD(1)) u_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_len(a_len),
    .in_valid(a_valid), .in_ready(a_rdy), .abort(a_abort),
    .seq(a_seq), .valid(a_vld), .busy(a_busy), .done(a_done)
  );

  sequence_serializer #(.DATA_W(16), .BIT_PERIOD(3)) u_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_len(b_len),
    .in_valid(b_valid), .in_ready(b_rdy), .abort(b_abort),
    .seq(b_seq), .valid(b_vld), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected events for a word whose "cycle 0" (accept cycle) is base.
  task automatic push_exp(input int u, input logic [15:0] d, input int l, input int base);
    int   eff;
    int   bp;
    exp_t e;
    eff = (l > 16) ? 16 : l;
    bp  = (u == 0) ? 1 : 3;
    if (eff == 0) begin
      e.cyc = base + 1;
      e.vsd = 3'b001;
      if (u == 0) qa.push_back(e); else qb.push_back(e);
    end else begin
      for (int k = 0; k < eff; k++) begin
        e.cyc = base + 1 + k * bp;
        e.vsd = {1'b1, d[eff-1-k], (k == eff - 1)};
        if (u == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
  endtask

  // Called #1 after a rising edge; offers for one cycle.
  task automatic offer(input int u, input logic [15:0] d, input int l, output int base);
    base = cyc;
    chk("rdy_at_offer", (u == 0) ? a_rdy : b_rdy, 1);
    push_exp(u, d, l, base);
    if (u == 0) begin a_data = d; a_len = 5'(l); a_valid = 1'b1; end
    else        begin b_data = d; b_len = 5'(l); b_valid = 1'b1; end
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int expc);
    int n;
    n = 0;
    while (!((u == 0) ? a_rdy : b_rdy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rdy_cycle", cyc, expc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_vld || a_done) begin
      if (qa.size() == 0) chk("a_extra", {29'd0, a_vld, a_seq, a_done}, 0);
      else begin
        e = qa.pop_front();
        chk("a_cyc", cyc, e.cyc);
        chk("a_vsd", {29'd0, a_vld, a_seq, a_done}, {29'd0, e.vsd});
      end
    end
    if (!a_vld && a_seq) chk("a_seq_idle", a_seq, 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_vld || b_done) begin
      if (qb.size() == 0) chk("b_extra", {29'd0, b_vld, b_seq, b_done}, 0);
      else begin
        e = qb.pop_front();
        chk("b_cyc", cyc, e.cyc);
        chk("b_vsd", {29'd0, b_vld, b_seq, b_done}, {29'd0, e.vsd});
      end
    end
    if (!b_vld && b_seq) chk("b_seq_idle", b_seq, 0);
  end

  initial begin
    int   base;
    int   l;
    exp_t e;
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    a_data = '0; a_len = '0; a_valid = 1'b0; a_abort = 1'b0;
    b_data = '0; b_len = '0; b_valid = 1'b0; b_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",  a_rdy, 1);
    chk("rst_vld",  a_vld, 0);
    chk("rst_seq",  a_seq, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rdy_b", b_rdy, 1);
    reset = 1'b0;

    // 5 bits 10110, period 1
    offer(0, 16'h0016, 5, base);
    wait_idle(0, base + 6);

    // 3 bits 101, period 3
    offer(1, 16'h0005, 3, base);
    wait_idle(1, base + 10);

    // zero length, then over-length clamped to 16
    offer(0, 16'hABCD, 0, base);
    wait_idle(0, base + 2);
    offer(0, 16'h9C3A, 20, base);
    wait_idle(0, base + 17);

    // single bit, period 3
    offer(1, 16'h0001, 1, base);
    wait_idle(1, base + 4);

    // back-to-back with in_valid held: second word offered while busy
    base = cyc;
    push_exp(0, 16'h0016, 5, base);
    a_data = 16'h0016; a_len = 5'd5; a_valid = 1'b1;
    @(posedge clk); #1;
    a_data = 16'h000B; a_len = 5'd4;
    push_exp(0, 16'h000B, 4, base + 6);
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_busy", a_busy, 1);
    a_valid = 1'b0;
    wait_idle(0, base + 11);

    // abort in IDLE blocks the accept
    a_data = 16'h00FF; a_len = 5'd8; a_valid = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_abort = 1'b0;
    chk("abt_idle_rdy",  a_rdy, 1);
    chk("abt_idle_busy", a_busy, 0);

    // abort on the 4th valid of a 16-bit word
    base = cyc;
    for (int k = 1; k <= 4; k++) begin
      e.cyc = base + k;
      e.vsd = 3'b110;
      qa.push_back(e);
    end
    a_data = 16'hFFFF; a_len = 5'd16; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    chk("abt_rdy", a_rdy, 1);
    chk("abt_vld", a_vld, 0);

    // random words, period 3
    for (int i = 0; i < 3; i++) begin
      l = $urandom_range(1, 16);
      offer(1, 16'($urandom), l, base);
      wait_idle(1, base + 1 + l * 3);
    end

    // reset during bit 3 of 8'hA5 (bits 1,0,1 seen)
    base = cyc;
    for (int k = 1; k <= 3; k++) begin
      e.cyc = base + k;
      e.vsd = {1'b1, (k != 2), 1'b0};
      qa.push_back(e);
    end
    a_data = 16'h00A5; a_len = 5'd8; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk("arst_vld",  a_vld, 0);
    chk("arst_seq",  a_seq, 0);
    chk("arst_rdy",  a_rdy, 1);
    chk("arst_busy", a_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // accept on the very first edge after reset
    offer(0, 16'h0003, 2, base);
    wait_idle(0, base + 3);

    repeat (5) @(posedge clk);
    #1;
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
